fl13_mult_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 13-bit floating-point multiplier (1 sign, 4 exponent, 8 mantissa bits). It accepts operand pairs over valid/ready handshakes and drives one registered operand pair into the multiplier. It waits a configurable latency, captures the product, and returns it to the originating requester over a response handshake. It sits between the requesters and the multiplier instance; the multiplier itself is external.

---
 rtl/fl13_mult_arbiter.sv | 105 ++++++++++
 tb/tb_fl13_mult_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fl13_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 13-bit float multiplier
// between two requesters; operands and product are registered here, no arithmetic.
module fl13_mult_arbiter #(
    parameter int NB_FLOAT = 13,
    parameter int MULT_LAT = 1
) (
    input  logic                  clock,
    input  logic                  i_reset_n,
    input  logic [1:0]            i_req_valid,
    input  logic [2*NB_FLOAT-1:0] i_req_a,
    input  logic [2*NB_FLOAT-1:0] i_req_b,
    output logic [1:0]            o_req_ready,
    output logic [1:0]            o_rsp_valid,
    output logic [NB_FLOAT-1:0]   o_rsp_data,
    input  logic [1:0]            i_rsp_ready,
    output logic [NB_FLOAT-1:0]   o_mult_op1,
    output logic [NB_FLOAT-1:0]   o_mult_op2,
    input  logic [NB_FLOAT-1:0]   i_mult_result,
    output logic                  o_busy,
    output logic                  o_grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MULT_LAT - 1);

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  gid_q, gid_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [NB_FLOAT-1:0]   op1_q, op1_d;
    logic [NB_FLOAT-1:0]   op2_q, op2_d;
    logic [NB_FLOAT-1:0]   prod_q, prod_d;
    logic                  grant;

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            gid_q   <= 1'b0;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        cnt_d       = cnt_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        prod_d      = prod_q;
        o_req_ready = 2'b00;
        o_rsp_valid = 2'b00;
        // The pointer only breaks ties; a lone requester is always granted.
        grant       = (i_req_valid == 2'b11) ? ptr_q : i_req_valid[1];

        case (state_q)
            S_IDLE: begin
                if (|i_req_valid) begin
                    o_req_ready[grant] = 1'b1;
                    state_d = S_WAIT;
                    gid_d   = grant;
                    cnt_d   = LAT_LOAD;
                    op1_d   = grant ? i_req_a[NB_FLOAT +: NB_FLOAT] : i_req_a[0 +: NB_FLOAT];
                    op2_d   = grant ? i_req_b[NB_FLOAT +: NB_FLOAT] : i_req_b[0 +: NB_FLOAT];
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    prod_d  = i_mult_result;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                o_rsp_valid[gid_q] = 1'b1;
                if (i_rsp_ready[gid_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = ~gid_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rsp_data = prod_q;
    assign o_mult_op1 = op1_q;
    assign o_mult_op2 = op2_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_grant_id = gid_q;

endmodule

// File: tb/tb_fl13_mult_arbiter.sv
// Scoreboard bench: two arbiter instances (MULT_LAT=1 with a multiplier stub,
// MULT_LAT=4 with a bench-driven product) checked through expected-response queues.
module tb_fl13_mult_arbiter;

    logic clk;
    logic rst_n;

    logic [1:0]  valid0, ready0, rvld0, rrdy0;
    logic [25:0] a0, b0;
    logic [12:0] rdata0, op1_0, op2_0, mres0;
    logic        busy0, gid0;

    logic [1:0]  valid1, ready1, rvld1, rrdy1;
    logic [25:0] a1, b1;
    logic [12:0] rdata1, op1_1, op2_1, mres1;
    logic        busy1, gid1;

    logic [13:0] q0[$];
    logic [13:0] q1[$];
    int checks;
    int errors;

    function automatic logic [12:0] stub(input logic [12:0] a, input logic [12:0] b);
        if (a == 13'h15C6 && b == 13'h0C1D) return 13'h1AEE;
        return a ^ b;
    endfunction

    assign mres0 = stub(op1_0, op2_0);

    fl13_mult_arbiter #(.NB_FLOAT(13), .MULT_LAT(1)) dut0 (
        .clock(clk), .i_reset_n(rst_n), .i_req_valid(valid0), .i_req_a(a0), .i_req_b(b0),
        .o_req_ready(ready0), .o_rsp_valid(rvld0), .o_rsp_data(rdata0), .i_rsp_ready(rrdy0),
        .o_mult_op1(op1_0), .o_mult_op2(op2_0), .i_mult_result(mres0),
        .o_busy(busy0), .o_grant_id(gid0)
    );

    fl13_mult_arbiter #(.NB_FLOAT(13), .MULT_LAT(4)) dut1 (
        .clock(clk), .i_reset_n(rst_n), .i_req_valid(valid1), .i_req_a(a1), .i_req_b(b1),
        .o_req_ready(ready1), .o_rsp_valid(rvld1), .o_rsp_data(rdata1), .i_rsp_ready(rrdy1),
        .o_mult_op1(op1_1), .o_mult_op2(op2_1), .i_mult_result(mres1),
        .o_busy(busy1), .o_grant_id(gid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("drain_timeout", (which == 0) ? q0.size() : q1.size(), 0);
    endtask

    // Monitor: a response is consumed on any edge where valid & ready are both high.
    initial begin
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ((rvld0 & rrdy0) != 2'b00) begin
                    if (q0.size() == 0) chk("dut0_unexpected_rsp", {30'd0, rvld0}, 32'd0);
                    else begin
                        e = q0.pop_front();
                        chk("dut0_rsp_id", {30'd0, rvld0}, e[13] ? 32'd2 : 32'd1);
                        chk("dut0_rsp_data", {19'd0, rdata0}, {19'd0, e[12:0]});
                    end
                end
                if ((rvld1 & rrdy1) != 2'b00) begin
                    if (q1.size() == 0) chk("dut1_unexpected_rsp", {30'd0, rvld1}, 32'd0);
                    else begin
                        e = q1.pop_front();
                        chk("dut1_rsp_id", {30'd0, rvld1}, e[13] ? 32'd2 : 32'd1);
                        chk("dut1_rsp_data", {19'd0, rdata1}, {19'd0, e[12:0]});
                    end
                end
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        valid0 = 2'b00; a0 = '0; b0 = '0; rrdy0 = 2'b00;
        valid1 = 2'b00; a1 = '0; b1 = '0; rrdy1 = 2'b00; mres1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {30'd0, ready0}, 0);
        chk("rst_rsp_valid", {30'd0, rvld0}, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_op1", {19'd0, op1_0}, 0);
        chk("rst_rsp_data", {19'd0, rdata0}, 0);
        chk("rst_grant_id", {31'd0, gid0}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Tie arbitration: both valid continuously, grants 0,1,0,1.
        @(posedge clk); #1;
        a0 = {13'h15C6, 13'h03CD};
        b0 = {13'h1B2B, 13'h1B2B};
        rrdy0 = 2'b11;
        valid0 = 2'b11;
        q0.push_back({1'b0, 13'h18E6});
        q0.push_back({1'b1, 13'h0EED});
        q0.push_back({1'b0, 13'h18E6});
        q0.push_back({1'b1, 13'h0EED});
        @(negedge clk);
        chk("tie_first_ready", {30'd0, ready0}, 32'd1);
        n = 0;
        while (q0.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("tie_timeout", q0.size(), 0);
        valid0 = 2'b00;

        // Single request on requester 0.
        @(posedge clk); #1;
        a0 = {13'h0000, 13'h15C6};
        b0 = {13'h0000, 13'h0C1D};
        valid0 = 2'b01;
        q0.push_back({1'b0, 13'h1AEE});
        @(negedge clk);
        chk("single_ready", {30'd0, ready0}, 32'd1);
        @(posedge clk); #1;
        valid0 = 2'b00;
        @(negedge clk);
        chk("single_op1", {19'd0, op1_0}, 32'h15C6);
        chk("single_op2", {19'd0, op2_0}, 32'h0C1D);
        chk("single_busy_wait", {31'd0, busy0}, 32'd1);
        chk("single_no_rsp_yet", {30'd0, rvld0}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_rsp_valid", {30'd0, rvld0}, 32'd1);
        chk("single_rsp_data", {19'd0, rdata0}, 32'h1AEE);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_busy_done", {31'd0, busy0}, 0);
        chk("single_op1_kept", {19'd0, op1_0}, 32'h15C6);

        // Response backpressure with a competing request and stray ready from requester 1.
        @(posedge clk); #1;
        a0 = {13'h03CD, 13'h15C6};
        b0 = {13'h1B2B, 13'h0C1D};
        rrdy0 = 2'b00;
        valid0 = 2'b01;
        q0.push_back({1'b0, 13'h1AEE});
        q0.push_back({1'b1, 13'h18E6});
        @(posedge clk); #1;
        valid0 = 2'b10;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            rrdy0 = (i % 2 == 1) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("bp_rsp_valid", {30'd0, rvld0}, 32'd1);
            chk("bp_rsp_data", {19'd0, rdata0}, 32'h1AEE);
            chk("bp_ready_low", {30'd0, ready0}, 0);
            @(posedge clk); #1;
        end
        chk("bp_no_completion", q0.size(), 2);
        rrdy0 = 2'b11;
        n = 0;
        while (q0.size() != 1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("bp_timeout", q0.size(), 1);
        @(posedge clk); #1;
        valid0 = 2'b00;
        drain(0);

        // MULT_LAT=4: only the value present at the fourth edge after accept is captured.
        @(posedge clk); #1;
        a1 = {13'h0000, 13'h15C6};
        b1 = {13'h0000, 13'h0C1D};
        rrdy1 = 2'b11;
        mres1 = 13'h1111;
        valid1 = 2'b01;
        q1.push_back({1'b0, 13'h0ABC});
        @(posedge clk); #1;
        valid1 = 2'b00;
        @(negedge clk);
        chk("lat4_busy", {31'd0, busy1}, 32'd1);
        @(posedge clk); #1;
        mres1 = 13'h1234;
        @(negedge clk);
        chk("lat4_no_rsp_e1", {30'd0, rvld1}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat4_no_rsp_e2", {30'd0, rvld1}, 0);
        @(posedge clk); #1;
        mres1 = 13'h0ABC;
        @(negedge clk);
        chk("lat4_no_rsp_e3", {30'd0, rvld1}, 0);
        @(posedge clk); #1;
        mres1 = 13'h1FFF;
        @(negedge clk);
        chk("lat4_rsp_valid", {30'd0, rvld1}, 32'd1);
        chk("lat4_rsp_data", {19'd0, rdata1}, 32'h0ABC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat4_idle", {31'd0, busy1}, 0);
        drain(1);

        // Reset in the middle of WAIT; pointer currently favours requester 1.
        @(posedge clk); #1;
        a1 = {13'h03CD, 13'h15C6};
        b1 = {13'h1B2B, 13'h0C1D};
        valid1 = 2'b11;
        @(posedge clk); #1;
        valid1 = 2'b00;
        @(negedge clk);
        chk("prerst_grant_id", {31'd0, gid1}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy1}, 0);
        chk("midrst_op1", {19'd0, op1_1}, 0);
        chk("midrst_op2", {19'd0, op2_1}, 0);
        chk("midrst_grant_id", {31'd0, gid1}, 0);
        chk("midrst_rsp_valid", {30'd0, rvld1}, 0);
        chk("midrst_rsp_data", {19'd0, rdata1}, 0);
        chk("midrst_ready", {30'd0, ready1}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("postrst_no_rsp", {30'd0, rvld1}, 0);
        end
        @(posedge clk); #1;
        mres1 = 13'h0777;
        valid1 = 2'b11;
        q1.push_back({1'b0, 13'h0777});
        @(negedge clk);
        chk("postrst_tie_ready", {30'd0, ready1}, 32'd1);
        @(posedge clk); #1;
        valid1 = 2'b00;
        drain(1);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
